home_event_scheduler: RTL and testbench

- Parametrised successor to the home-automation sensor arbiter.
- Each cycle it walks a programmable schedule of start channels and grants one pending sensor event using rotating-start priority.
- Adds N digital sensor channels plus two temperature channels, a configurable schedule, sticky pending capture and a Valid/Ack output handshake.
- Sits between the sensor input synchronisers and the actuator/display driver.

---
 rtl/home_sched_pkg.sv | 17 +
 rtl/rr_pick.sv | 30 +++
 rtl/home_event_scheduler.sv | 106 ++++++++++
 tb/tb_home_event_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/home_sched_pkg.sv
// Shared constants for the home event scheduler.
// Holds the default schedule, channel indices and the stat counter width.
package home_sched_pkg;

  localparam logic [51:0] SCHED_DEF = 52'h2310420130210;
  localparam int CODE_NONE = 0;

  localparam int CH_FD  = 0;
  localparam int CH_RD  = 1;
  localparam int CH_FA  = 2;
  localparam int CH_WIN = 3;
  localparam int CH_TL  = 4;
  localparam int CH_TH  = 5;

  localparam int STAT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-start priority picker.
// Scans upward from i_start, wrapping, and returns the first set bit.
module rr_pick
  import home_sched_pkg::*;
#(
  parameter int N_CH = 6,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_vec,
  input  logic [IW-1:0]   i_start,
  output logic [N_CH-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Walk offsets high to low so the lowest offset wins last.
  always_comb begin
    int j;
    o_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = int'(i_start) + k;
      if (j >= N_CH) j = j - N_CH;
      if (i_vec[j]) o_idx = IW'(j);
    end
  end

  assign o_any    = |i_vec;
  assign o_onehot = o_any ? (N_CH'(1) << o_idx) : '0;

endmodule

// File: rtl/home_event_scheduler.sv
// Scheduled rotating-priority grant of sensor and temperature events.
// Define HOME_SCHED_STATS_EN to add per-channel grant counters.
module home_event_scheduler
  import home_sched_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int TW        = 7,
  parameter int T_LOW     = 50,
  parameter int T_HIGH    = 70,
  parameter int SCHED_LEN = 13,
  parameter int SIW       = 4,
  parameter logic [SCHED_LEN*SIW-1:0] SCHED = SCHED_DEF,
  parameter int STICKY    = 1,
  localparam int N_CH     = N_DIG + 2,
  localparam int CW       = $clog2(N_CH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_DIG-1:0] Req,
  input  logic [TW-1:0]    ST,
  input  logic             Ack,
  output logic             Valid,
  output logic [N_CH-1:0]  Grant,
  output logic [CW-1:0]    Code,
  output logic [N_CH-1:0]  Pending
`ifdef HOME_SCHED_STATS_EN
  ,
  input  logic [CW-1:0]     StatSel,
  output logic [STAT_W-1:0] StatCnt
`endif
);

  localparam int IW = $clog2(N_CH);
  localparam int PW = (SCHED_LEN > 1) ? $clog2(SCHED_LEN) : 1;
  localparam logic [TW-1:0] LP_TLO = TW'(T_LOW);
  localparam logic [TW-1:0] LP_THI = TW'(T_HIGH);

  logic [PW-1:0]   r_ptr;
  logic [N_CH-1:0] r_pend;
  logic            r_valid;
  logic [N_CH-1:0] r_grant;
  logic [CW-1:0]   r_code;

  logic [N_CH-1:0] w_req_eff;
  logic [N_CH-1:0] w_pend_n;
  logic            w_adv;
  logic [SIW-1:0]  w_sentry;
  logic [IW-1:0]   w_start;
  logic [N_CH-1:0] w_oh;
  logic [IW-1:0]   w_idx;
  logic            w_any;

  assign w_req_eff = {ST > LP_THI, ST < LP_TLO, Req};
  assign w_pend_n  = (STICKY != 0) ? (r_pend | w_req_eff) : w_req_eff;
  assign w_adv     = !r_valid || Ack;

  // Out-of-range schedule entries fall back to channel 0.
  assign w_sentry = SCHED[32'(r_ptr) * SIW +: SIW];
  assign w_start  = (32'(w_sentry) >= N_CH) ? '0 : IW'(w_sentry);

  rr_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .i_vec    (w_pend_n),
    .i_start  (w_start),
    .o_onehot (w_oh),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr   <= '0;
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_code  <= CW'(CODE_NONE);
    end else if (w_adv) begin
      r_pend  <= w_pend_n & ~w_oh;
      r_valid <= w_any;
      r_grant <= w_oh;
      r_code  <= w_any ? CW'(w_idx) + CW'(1) : CW'(CODE_NONE);
      r_ptr   <= (32'(r_ptr) == SCHED_LEN - 1) ? '0 : r_ptr + PW'(1);
    end else begin
      r_pend  <= w_pend_n;
    end
  end

  assign Valid   = r_valid;
  assign Grant   = r_grant;
  assign Code    = r_code;
  assign Pending = r_pend;

`ifdef HOME_SCHED_STATS_EN
  logic [STAT_W-1:0] r_cnt [N_CH];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else if (w_adv && w_any && (r_cnt[w_idx] != '1)) begin
      r_cnt[w_idx] <= r_cnt[w_idx] + STAT_W'(1);
    end
  end

  assign StatCnt = (32'(StatSel) < N_CH) ? r_cnt[IW'(StatSel)] : '0;
`endif

endmodule

// File: tb/tb_home_event_scheduler.sv
// Scoreboard bench: one sticky and one live-level scheduler share stimulus.
// Driver queues expected outputs per cycle; a negedge monitor pops and checks.
module tb_home_event_scheduler;
  import home_sched_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Req = '0;
  logic [6:0] ST  = 7'd60;
  logic       Ack = 1'b0;

  logic       v_s, v_l;
  logic [5:0] g_s, g_l, p_s, p_l;
  logic [2:0] c_s, c_l;
`ifdef HOME_SCHED_STATS_EN
  logic [2:0] StatSel = '0;
  logic [7:0] sc_s, sc_l;
`endif

  always #5 Clk = ~Clk;

  home_event_scheduler #(.STICKY(1)) u_s (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ST(ST), .Ack(Ack),
    .Valid(v_s), .Grant(g_s), .Code(c_s), .Pending(p_s)
`ifdef HOME_SCHED_STATS_EN
    , .StatSel(StatSel), .StatCnt(sc_s)
`endif
  );

  home_event_scheduler #(.STICKY(0)) u_l (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ST(ST), .Ack(Ack),
    .Valid(v_l), .Grant(g_l), .Code(c_l), .Pending(p_l)
`ifdef HOME_SCHED_STATS_EN
    , .StatSel(StatSel), .StatCnt(sc_l)
`endif
  );

  typedef struct {
    int         cyc;
    int         inst;
    logic       v;
    logic [2:0] code;
    logic [5:0] pend;
    int         stat;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge Clk) cyc++;

  task automatic exp1(int inst, logic v, logic [2:0] code,
                      logic [5:0] pend, string nm, int stat = -1);
    exp_t e;
    e.cyc  = cyc + 1;
    e.inst = inst;
    e.v    = v;
    e.code = code;
    e.pend = pend;
    e.stat = stat;
    e.nm   = nm;
    q.push_back(e);
  endtask

  task automatic exp2(logic v, logic [2:0] code,
                      logic [5:0] pend, string nm);
    exp1(0, v, code, pend, nm);
    exp1(1, v, code, pend, nm);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(string nm);
    Rst = 1'b1;
    exp2(1'b0, 3'd0, 6'd0, nm);
    tick();
    Rst = 1'b0;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    logic       vv, bad;
    logic [2:0] cc;
    logic [5:0] gg, pp, eg;
    int         ss;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      vv = (e.inst == 0) ? v_s : v_l;
      cc = (e.inst == 0) ? c_s : c_l;
      gg = (e.inst == 0) ? g_s : g_l;
      pp = (e.inst == 0) ? p_s : p_l;
      ss = -1;
`ifdef HOME_SCHED_STATS_EN
      ss = (e.inst == 0) ? int'(sc_s) : int'(sc_l);
`endif
      eg  = (e.code != 3'd0) ? (6'd1 << (e.code - 3'd1)) : 6'd0;
      bad = (e.cyc != cyc) || (vv !== e.v) || (cc !== e.code) ||
            (gg !== eg) || (pp !== e.pend) ||
            ((e.stat >= 0) && (ss != e.stat));
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s inst%0d cyc%0d: got v=%b code=%0d grant=%b pend=%b stat=%0d, want v=%b code=%0d grant=%b pend=%b stat=%0d",
                 e.nm, e.inst, cyc, vv, cc, gg, pp, ss,
                 e.v, e.code, eg, e.pend, e.stat);
      end
    end
  end

  int rot_codes [9] = '{1, 2, 3, 1, 4, 2, 1, 3, 5};
  int t_st      [7] = '{50, 70, 49, 71, 0, 127, 60};
  int t_code    [7] = '{0, 0, 5, 6, 5, 6, 0};

  initial begin
    logic [2:0] c;

    do_reset("reset");

    Req = 4'h0; ST = 7'd60; Ack = 1'b0;
    repeat (26) begin
      exp2(1'b0, 3'd0, 6'd0, "idle");
      tick();
    end

    // Pointer is back at slot 0 after 26 idle advances.
    Req = 4'hF; ST = 7'd40; Ack = 1'b1;
    foreach (rot_codes[i]) begin
      c = 3'(rot_codes[i]);
      exp2(1'b1, c, 6'b011111 & ~(6'd1 << (c - 3'd1)), "rotate");
      tick();
    end

    do_reset("reset_b");
    ST = 7'd60; Ack = 1'b0;
    Req = 4'b0001; exp2(1'b1, 3'd1, 6'd0, "stall_grant");   tick();
    Req = 4'b0000; exp2(1'b1, 3'd1, 6'd0, "stall_hold1");   tick();
    Req = 4'b0100;
    exp1(0, 1'b1, 3'd1, 6'b000100, "stall_accum");
    exp1(1, 1'b1, 3'd1, 6'b000100, "stall_accum");          tick();
    Req = 4'b0000;
    exp1(0, 1'b1, 3'd1, 6'b000100, "stall_keep");
    exp1(1, 1'b1, 3'd1, 6'b000000, "stall_keep");           tick();
    Req = 4'hF; Ack = 1'b1;
    exp2(1'b1, 3'd2, 6'b001101, "resume_slot1");            tick();
    Req = 4'h0;
    exp1(0, 1'b1, 3'd3, 6'b001001, "sticky_remember");
    exp1(1, 1'b0, 3'd0, 6'b000000, "live_forget");          tick();

    do_reset("reset_c");
    Req = 4'h0; ST = 7'd60; Ack = 1'b1;
    repeat (2) begin
      exp2(1'b0, 3'd0, 6'd0, "pre_slot2");
      tick();
    end
    Req = 4'b0110;
    exp2(1'b1, 3'd3, 6'b000010, "fa_over_rd");              tick();
    Req = 4'b0100;
    exp1(0, 1'b1, 3'd2, 6'b000100, "rd_latched");
    exp1(1, 1'b1, 3'd3, 6'b000000, "rd_lost");              tick();
    exp2(1'b1, 3'd3, 6'b000000, "fa_slot4");                tick();

    Req = 4'h0; Ack = 1'b1;
    foreach (t_st[i]) begin
      ST = 7'(t_st[i]);
      exp2(t_code[i] != 0, 3'(t_code[i]), 6'd0, "temp");
      tick();
    end

    Req = 4'b0001; Ack = 1'b0; ST = 7'd60;
    exp2(1'b1, 3'd1, 6'd0, "pre_rst");                      tick();
    Rst = 1'b1; Req = 4'hF; Ack = 1'b1;
    exp2(1'b0, 3'd0, 6'd0, "rst_mid_stall");                tick();
    Rst = 1'b0; Req = 4'h0;
    exp2(1'b0, 3'd0, 6'd0, "post_rst");                     tick();

`ifdef HOME_SCHED_STATS_EN
    StatSel = 3'd0;
    Rst = 1'b1;
    exp1(0, 1'b0, 3'd0, 6'd0, "stat_rst", 0);               tick();
    Rst = 1'b0;
    Req = 4'b0001; Ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp1(0, 1'b1, 3'd1, 6'd0, "stat_count", i);
      tick();
    end
    Req = 4'h0;
    exp1(0, 1'b0, 3'd0, 6'd0, "stat_three", 3);             tick();
    Req = 4'b0001;
    for (int i = 1; i <= 300; i++) begin
      exp1(0, 1'b1, 3'd1, 6'd0, "stat_sat", (3 + i > 255) ? 255 : 3 + i);
      tick();
    end
    Req = 4'h0; StatSel = 3'd6;
    exp1(0, 1'b0, 3'd0, 6'd0, "stat_badsel", 0);            tick();
    StatSel = 3'd0;
    exp1(0, 1'b0, 3'd0, 6'd0, "stat_255", 255);             tick();
    Rst = 1'b1;
    exp1(0, 1'b0, 3'd0, 6'd0, "stat_clear", 0);             tick();
    Rst = 1'b0;
`endif

    repeat (2) tick();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d unchecked entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
